// File: rtl/uart_wb_ctrl.sv
// Wishbone-attached UART: DATA/STATUS/DIVISOR/CTRL registers, TX and RX byte FIFOs,
// and an 8x-oversampled serializer/deserializer driven by a programmable tick.

module uart_wb_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] pushData,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign head  = mem[rdPtr[AW-1:0]];

    // Pointer update; the owner only pushes with room (or alongside a pop) and pops when non-empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_ONE;
            if (pop)  rdPtr <= rdPtr + PTR_ONE;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr[AW-1:0]] <= pushData;
    end
endmodule

module uart_wb_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 26,
    parameter int STOP_BITS  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        RxD,
    output logic        TxD,
    output logic        irq
);
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rxState_t;

    localparam logic [15:0] DIV_INIT  = 16'(DIV_RESET);
    localparam logic        LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    logic [15:0] divisor;
    logic [15:0] tickCnt;
    logic        tick;
    logic [1:0]  ctrl;
    logic        rxOverrun;
    logic        frameErr;
    logic [31:0] readData;

    logic        access, rdAccess, wrAccess;
    logic        dataWrite, dataRead, statusRead, divWrite, ctrlWrite;

    txState_t    txState;
    logic [2:0]  txPhase;
    logic [2:0]  txBitIdx;
    logic        txStopIdx;
    logic [7:0]  txShift;
    logic        txPush, txPop, txEmpty, txFull, txIdle, txFrameEnd;
    logic [7:0]  txHead;

    rxState_t    rxState;
    logic [1:0]  rxSync;
    logic        rxBit;
    logic [2:0]  rxPhase;
    logic [2:0]  rxBitIdx;
    logic [7:0]  rxShift;
    logic        rxStopSample, rxPush, rxPop, rxEmpty, rxFull;
    logic        setOverrun, setFrameErr;
    logic [7:0]  rxHead;

    logic        unusedDat;
    assign unusedDat = ^wb_dat_i[31:16];

    assign access     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign rdAccess   = access & ~wb_we_i;
    assign wrAccess   = access & wb_we_i;
    assign dataWrite  = wrAccess & (wb_adr_i == 2'd0);
    assign divWrite   = wrAccess & (wb_adr_i == 2'd2);
    assign ctrlWrite  = wrAccess & (wb_adr_i == 2'd3);
    assign dataRead   = rdAccess & (wb_adr_i == 2'd0);
    assign statusRead = rdAccess & (wb_adr_i == 2'd1);

    assign tick = (tickCnt == divisor);

    // Full is judged before the serializer's pop on the same edge, so a push into a full FIFO is lost.
    assign txPush     = dataWrite & ~txFull;
    assign txFrameEnd = (txState == TX_STOP) && tick && (txPhase == 3'd7) && (txStopIdx == LAST_STOP);
    assign txPop      = ~txEmpty && ((txState == TX_IDLE) || txFrameEnd);
    assign txIdle     = txEmpty && (txState == TX_IDLE);

    assign rxBit        = rxSync[1];
    assign rxPop        = dataRead & ~rxEmpty;
    assign rxStopSample = (rxState == RX_STOP) && tick && (rxPhase == 3'd7);
    assign rxPush       = rxStopSample & rxBit & (~rxFull | rxPop);
    assign setOverrun   = rxStopSample & rxBit & rxFull & ~rxPop;
    assign setFrameErr  = rxStopSample & ~rxBit;

    uart_wb_fifo #(.DEPTH(FIFO_DEPTH)) txFifo (
        .clk(clk), .rst(rst), .push(txPush), .pushData(wb_dat_i[7:0]),
        .pop(txPop), .head(txHead), .empty(txEmpty), .full(txFull)
    );

    uart_wb_fifo #(.DEPTH(FIFO_DEPTH)) rxFifo (
        .clk(clk), .rst(rst), .push(rxPush), .pushData(rxShift),
        .pop(rxPop), .head(rxHead), .empty(rxEmpty), .full(rxFull)
    );

    // Register read multiplexer.
    always_comb begin
        readData = 32'd0;
        case (wb_adr_i)
            2'd0: begin
                if (rxEmpty) readData = 32'd0;
                else         readData = {24'd0, rxHead};
            end
            2'd1:    readData = {27'd0, frameErr, rxOverrun, txIdle, txFull, ~rxEmpty};
            2'd2:    readData = {16'd0, divisor};
            2'd3:    readData = {30'd0, ctrl};
            default: readData = 32'd0;
        endcase
    end

    // Bus handshake, writable registers, sticky flags and interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= 32'd0;
            divisor   <= DIV_INIT;
            ctrl      <= 2'd0;
            rxOverrun <= 1'b0;
            frameErr  <= 1'b0;
            irq       <= 1'b0;
        end else begin
            wb_ack_o <= access;
            wb_dat_o <= rdAccess ? readData : 32'd0;
            if (divWrite)  divisor <= wb_dat_i[15:0];
            if (ctrlWrite) ctrl    <= wb_dat_i[1:0];
            if (setOverrun)      rxOverrun <= 1'b1;
            else if (statusRead) rxOverrun <= 1'b0;
            if (setFrameErr)     frameErr  <= 1'b1;
            else if (statusRead) frameErr  <= 1'b0;
            irq <= (ctrl[0] & ~rxEmpty) | (ctrl[1] & txIdle);
        end
    end

    // Free-running oversampling tick; a DIVISOR write restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 tickCnt <= 16'd0;
        else if (divWrite || tick) tickCnt <= 16'd0;
        else                     tickCnt <= tickCnt + 16'd1;
    end

    // Transmit serializer; a pending byte starts right after the last stop tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txState   <= TX_IDLE;
            txPhase   <= 3'd0;
            txBitIdx  <= 3'd0;
            txStopIdx <= 1'b0;
            txShift   <= 8'd0;
            TxD       <= 1'b1;
        end else begin
            case (txState)
                TX_IDLE: begin
                    if (txPop) begin
                        txShift <= txHead;
                        txPhase <= 3'd0;
                        txState <= TX_START;
                        TxD     <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        txPhase <= txPhase + 3'd1;
                        if (txPhase == 3'd7) begin
                            txState  <= TX_DATA;
                            txBitIdx <= 3'd0;
                            TxD      <= txShift[0];
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        txPhase <= txPhase + 3'd1;
                        if (txPhase == 3'd7) begin
                            if (txBitIdx == 3'd7) begin
                                txState   <= TX_STOP;
                                txStopIdx <= 1'b0;
                                TxD       <= 1'b1;
                            end else begin
                                txBitIdx <= txBitIdx + 3'd1;
                                txShift  <= {1'b0, txShift[7:1]};
                                TxD      <= txShift[1];
                            end
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        txPhase <= txPhase + 3'd1;
                        if (txPhase == 3'd7) begin
                            if (txStopIdx != LAST_STOP) begin
                                txStopIdx <= 1'b1;
                            end else if (txPop) begin
                                txShift <= txHead;
                                txState <= TX_START;
                                TxD     <= 1'b0;
                            end else begin
                                txState <= TX_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    txState <= TX_IDLE;
                    TxD     <= 1'b1;
                end
            endcase
        end
    end

    // Receive deserializer: start validated mid-bit, then one sample every 8 ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxSync   <= 2'b11;
            rxState  <= RX_IDLE;
            rxPhase  <= 3'd0;
            rxBitIdx <= 3'd0;
            rxShift  <= 8'd0;
        end else begin
            rxSync <= {rxSync[0], RxD};
            case (rxState)
                RX_IDLE: begin
                    if (!rxBit) begin
                        rxState <= RX_START;
                        rxPhase <= 3'd0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        rxPhase <= rxPhase + 3'd1;
                        if (rxPhase == 3'd3) begin
                            if (rxBit) begin
                                rxState <= RX_IDLE;
                            end else begin
                                rxState  <= RX_DATA;
                                rxPhase  <= 3'd0;
                                rxBitIdx <= 3'd0;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rxPhase <= rxPhase + 3'd1;
                        if (rxPhase == 3'd7) begin
                            rxShift  <= {rxBit, rxShift[7:1]};
                            rxBitIdx <= rxBitIdx + 3'd1;
                            if (rxBitIdx == 3'd7) rxState <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        rxPhase <= rxPhase + 3'd1;
                        if (rxPhase == 3'd7) rxState <= rxBit ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rxBit) rxState <= RX_IDLE;
                end
                default: rxState <= RX_IDLE;
            endcase
        end
    end
endmodule
